// File: rtl/rom_read_arbiter_if.sv
// Request/grant/response bundle for both ROM consumers plus the ROM-side
// en/address/data wires, as seen by the shared-ROM arbiter.
interface rom_read_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_en, rom_addr
    );

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_en, rom_addr
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM between two requesters.
// All outputs are registered; one read in flight at a time.
//
// state | meaning
// IDLE  | no read in flight; sample requests, grant winner, launch ROM read
// WAIT  | ROM read in flight; count down ROM latency, then return data
module rom_read_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    rom_read_arbiter_if.slave  bus
);
    localparam int CNT_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              sel_q, sel_d;
    logic              win;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
            sel_q      <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            sel_q      <= sel_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        sel_d      = sel_q;
        win        = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rom_en_d   = rom_en_q;
        rom_addr_d = rom_addr_q;

        case (state_q)
            IDLE: begin
                rom_en_d = 1'b0;
                if (bus.req0 || bus.req1) begin
                    // prio_q names the port that wins a tie: the one not granted last
                    win        = (bus.req0 && bus.req1) ? prio_q : bus.req1;
                    sel_d      = win;
                    prio_d     = ~win;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    rom_en_d   = 1'b1;
                    rom_addr_d = win ? bus.addr1 : bus.addr0;
                    cnt_d      = CNT_W'(ROM_LAT);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (sel_q) begin
                        rdata1_d  = bus.rom_data;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = bus.rom_data;
                        rvalid0_d = 1'b1;
                    end
                    rom_en_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench: instance 0 uses ROM_LAT=1, instance 1 uses ROM_LAT=3.
// ROM model returns 16'hC000 | address through a LAT-deep register pipe.
module tb_rom_read_arbiter;
    localparam int AW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]    req0_s, req1_s, gnt0_s, gnt1_s, rvalid0_s, rvalid1_s, rom_en_s;
    logic [AW-1:0] addr0_s [2];
    logic [AW-1:0] addr1_s [2];
    logic [AW-1:0] rom_addr_s [2];
    logic [DW-1:0] rdata0_s [2];
    logic [DW-1:0] rdata1_s [2];

    typedef struct {int port; logic [DW-1:0] data;} rsp_t;
    typedef struct {int port; int gap;} gnt_t;

    rsp_t          rsp_q [2][$];
    gnt_t          gnt_q [2][$];
    int            last_gnt [2][2];
    int            last_any [2];
    logic [DW-1:0] exp_rdata [2][2];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        rom_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW-1:0] rom_pipe [LAT];

        assign bus.req0  = req0_s[g];
        assign bus.req1  = req1_s[g];
        assign bus.addr0 = addr0_s[g];
        assign bus.addr1 = addr1_s[g];
        assign gnt0_s[g]     = bus.gnt0;
        assign gnt1_s[g]     = bus.gnt1;
        assign rvalid0_s[g]  = bus.rvalid0;
        assign rvalid1_s[g]  = bus.rvalid1;
        assign rdata0_s[g]   = bus.rdata0;
        assign rdata1_s[g]   = bus.rdata1;
        assign rom_en_s[g]   = bus.rom_en;
        assign rom_addr_s[g] = bus.rom_addr;

        always @(posedge clk) begin
            if (bus.rom_en) rom_pipe[0] <= 16'hC000 | DW'(bus.rom_addr);
            for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
        assign bus.rom_data = rom_pipe[LAT-1];

        rom_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        always @(negedge clk) begin
            int p;
            gnt_t ge;
            rsp_t re;
            logic [DW-1:0] dat;
            if (rst_n) begin
                if (bus.gnt0 || bus.gnt1) begin
                    check($sformatf("d%0d_gnt_exclusive", g), 32'(bus.gnt0 & bus.gnt1), 0);
                    p = bus.gnt1 ? 1 : 0;
                    if (gnt_q[g].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL d%0d_unexpected_gnt: got gnt on port %0d, expected none (cycle %0d)", g, p, cyc);
                    end else begin
                        ge = gnt_q[g].pop_front();
                        check($sformatf("d%0d_gnt_port", g), p, ge.port);
                        if (ge.gap > 0) check($sformatf("d%0d_gnt_gap", g), cyc - last_any[g], ge.gap);
                    end
                    last_gnt[g][p] = cyc;
                    last_any[g]    = cyc;
                end
                if (bus.rvalid0 || bus.rvalid1) begin
                    check($sformatf("d%0d_rvalid_exclusive", g), 32'(bus.rvalid0 & bus.rvalid1), 0);
                    p   = bus.rvalid1 ? 1 : 0;
                    dat = p ? bus.rdata1 : bus.rdata0;
                    if (rsp_q[g].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL d%0d_unexpected_rvalid: got rvalid on port %0d data %0h, expected none (cycle %0d)", g, p, dat, cyc);
                    end else begin
                        re = rsp_q[g].pop_front();
                        check($sformatf("d%0d_rsp_port", g), p, re.port);
                        check($sformatf("d%0d_rdata", g), dat, re.data);
                        check($sformatf("d%0d_latency", g), cyc - last_gnt[g][p], LAT + 1);
                        check($sformatf("d%0d_other_rdata_held", g),
                              p ? bus.rdata0 : bus.rdata1, exp_rdata[g][1-p]);
                        exp_rdata[g][p] = re.data;
                    end
                end
            end
        end
    end

    task automatic drive(int d, int p, logic r, logic [AW-1:0] a);
        if (p == 0) begin
            req0_s[d]  = r;
            addr0_s[d] = a;
        end else begin
            req1_s[d]  = r;
            addr1_s[d] = a;
        end
    endtask

    task automatic wait_gnt(int d, int p);
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (p == 0) ? gnt0_s[d] : gnt1_s[d];
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL d%0d_gnt%0d_timeout: got no grant in 20 cycles, expected one", d, p);
        end
    endtask

    task automatic wait_any_gnt(int d);
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = gnt0_s[d] | gnt1_s[d];
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL d%0d_any_gnt_timeout: got no grant in 20 cycles, expected one", d);
        end
    endtask

    task automatic clear_exp();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) exp_rdata[d][p] = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        clear_exp();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_idle_outputs(int d, string tag);
        check($sformatf("%s_gnt0", tag), 32'(gnt0_s[d]), 0);
        check($sformatf("%s_gnt1", tag), 32'(gnt1_s[d]), 0);
        check($sformatf("%s_rvalid0", tag), 32'(rvalid0_s[d]), 0);
        check($sformatf("%s_rvalid1", tag), 32'(rvalid1_s[d]), 0);
        check($sformatf("%s_rdata0", tag), 32'(rdata0_s[d]), 0);
        check($sformatf("%s_rdata1", tag), 32'(rdata1_s[d]), 0);
        check($sformatf("%s_rom_en", tag), 32'(rom_en_s[d]), 0);
        check($sformatf("%s_rom_addr", tag), 32'(rom_addr_s[d]), 0);
    endtask

    initial begin
        req0_s = '0;
        req1_s = '0;
        for (int d = 0; d < 2; d++) begin
            addr0_s[d] = '0;
            addr1_s[d] = '0;
            last_any[d] = 0;
            last_gnt[d][0] = 0;
            last_gnt[d][1] = 0;
        end
        clear_exp();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle_outputs(0, "reset_d0");
        check_idle_outputs(1, "reset_d1");

        // single read on port 0
        gnt_q[0].push_back('{port: 0, gap: 0});
        rsp_q[0].push_back('{port: 0, data: 16'hC004});
        @(posedge clk);
        #1 drive(0, 0, 1'b1, 4'd4);
        wait_gnt(0, 0);
        check("t1_rom_addr", 32'(rom_addr_s[0]), 4);
        check("t1_rom_en", 32'(rom_en_s[0]), 1);
        @(posedge clk);
        #1 drive(0, 0, 1'b0, 4'd4);
        repeat (4) @(posedge clk);
        #1 check("t1_rdata0_held", 32'(rdata0_s[0]), 32'h0000C004);
        check("t1_rdata1_untouched", 32'(rdata1_s[0]), 0);

        // both ports held: alternating grants every 3 cycles, starting from port 0
        do_reset();
        gnt_q[0].push_back('{port: 0, gap: 0});
        gnt_q[0].push_back('{port: 1, gap: 3});
        gnt_q[0].push_back('{port: 0, gap: 3});
        gnt_q[0].push_back('{port: 1, gap: 3});
        for (int i = 0; i < 2; i++) begin
            rsp_q[0].push_back('{port: 0, data: 16'hC00A});
            rsp_q[0].push_back('{port: 1, data: 16'hC007});
        end
        drive(0, 0, 1'b1, 4'd10);
        drive(0, 1, 1'b1, 4'd7);
        for (int i = 0; i < 4; i++) wait_any_gnt(0);
        @(posedge clk);
        #1 drive(0, 0, 1'b0, 4'd10);
        drive(0, 1, 1'b0, 4'd7);
        repeat (5) @(posedge clk);

        // back-to-back on port 1, max then zero address
        gnt_q[0].push_back('{port: 1, gap: 0});
        gnt_q[0].push_back('{port: 1, gap: 3});
        rsp_q[0].push_back('{port: 1, data: 16'hC00F});
        rsp_q[0].push_back('{port: 1, data: 16'hC000});
        #1 drive(0, 1, 1'b1, 4'd15);
        wait_gnt(0, 1);
        @(posedge clk);
        #1 drive(0, 1, 1'b1, 4'd0);
        wait_gnt(0, 1);
        @(posedge clk);
        #1 drive(0, 1, 1'b0, 4'd0);
        repeat (4) @(posedge clk);

        // reset while a port-0 read is in flight: dropped, outputs cleared at once
        gnt_q[0].push_back('{port: 0, gap: 0});
        #1 drive(0, 0, 1'b1, 4'd3);
        wait_gnt(0, 0);
        @(posedge clk);
        #1 drive(0, 0, 1'b0, 4'd3);
        rst_n = 1'b0;
        clear_exp();
        #1 check_idle_outputs(0, "t4_async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        gnt_q[0].push_back('{port: 1, gap: 0});
        rsp_q[0].push_back('{port: 1, data: 16'hC002});
        #1 drive(0, 1, 1'b1, 4'd2);
        wait_gnt(0, 1);
        @(posedge clk);
        #1 drive(0, 1, 1'b0, 4'd2);
        repeat (4) @(posedge clk);

        // port 0 withdraws before being granted; port 1 address change mid-read ignored
        gnt_q[0].push_back('{port: 1, gap: 0});
        rsp_q[0].push_back('{port: 1, data: 16'hC005});
        #1 drive(0, 1, 1'b1, 4'd5);
        wait_gnt(0, 1);
        @(posedge clk);
        #1 drive(0, 1, 1'b0, 4'd0);
        drive(0, 0, 1'b1, 4'd9);
        @(posedge clk);
        #1 drive(0, 0, 1'b0, 4'd9);
        repeat (6) @(posedge clk);
        #1 check("t5_rdata0_unchanged", 32'(rdata0_s[0]), 0);

        // ROM_LAT=3 instance
        gnt_q[1].push_back('{port: 0, gap: 0});
        rsp_q[1].push_back('{port: 0, data: 16'hC002});
        drive(1, 0, 1'b1, 4'd2);
        wait_gnt(1, 0);
        @(posedge clk);
        #1 drive(1, 0, 1'b0, 4'd2);
        repeat (7) @(posedge clk);
        #1 check("t6_rdata0_held", 32'(rdata0_s[1]), 32'h0000C002);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_gnt_queue_drained", d), gnt_q[d].size(), 0);
            check($sformatf("d%0d_rsp_queue_drained", d), rsp_q[d].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation time limit, expected test completion");
        $fatal(1, "timeout");
    end
endmodule
